wishbone_to_axi4_master: RTL and testbench

Bridge that accepts single Wishbone classic (pipelined mode not supported) slave cycles and issues the matching single-beat AXI4 master transactions. It sits between Wishbone-side initiators (controller, debug/UART command engine) and AXI4 memory or peripheral subsystems. It pairs with the existing AXI4-slave-to-Wishbone-master bridge to give both crossing directions. One transaction is outstanding at a time; AXI error responses are reported as WB_ERR.

---
 rtl/wishbone_to_axi4_master_pkg.sv | 30 +++
 rtl/wishbone_to_axi4_master_if.sv | 80 ++++++++
 rtl/wishbone_to_axi4_master.sv | 154 +++++++++++++++
 tb/tb_wishbone_to_axi4_master.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_to_axi4_master_pkg.sv
// Shared definitions for the Wishbone <-> AXI4 bridges: FSM states, AXI response and burst codes.
package wb_axi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StDone
  } bridge_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // AxSIZE encoding for a full-width beat of the given byte count.
  function automatic logic [2:0] axi_size(input int unsigned bytes);
    logic [2:0] sz;
    sz = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) sz = 3'(i);
    end
    return sz;
  endfunction

endpackage

// File: rtl/wishbone_to_axi4_master_if.sv
// Wishbone classic slave side plus AXI4 master side of the bridge, bundled as one interface.
interface wishbone_to_axi4_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);
  logic                      WB_CYC;
  logic                      WB_STB;
  logic                      WB_WE;
  logic [ADDR_WIDTH-1:0]     WB_ADDR;
  logic [DATA_WIDTH-1:0]     WB_WDATA;
  logic [DATA_WIDTH/8-1:0]   WB_SEL;
  logic [DATA_WIDTH-1:0]     WB_RDATA;
  logic                      WB_ACK;
  logic                      WB_ERR;

  logic [ID_WIDTH-1:0]       M_AXI_AWID;
  logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR;
  logic [7:0]                M_AXI_AWLEN;
  logic [2:0]                M_AXI_AWSIZE;
  logic [1:0]                M_AXI_AWBURST;
  logic                      M_AXI_AWVALID;
  logic                      M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]     M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB;
  logic                      M_AXI_WLAST;
  logic                      M_AXI_WVALID;
  logic                      M_AXI_WREADY;
  logic [ID_WIDTH-1:0]       M_AXI_BID;
  logic [1:0]                M_AXI_BRESP;
  logic                      M_AXI_BVALID;
  logic                      M_AXI_BREADY;

  logic [ID_WIDTH-1:0]       M_AXI_ARID;
  logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR;
  logic [7:0]                M_AXI_ARLEN;
  logic [2:0]                M_AXI_ARSIZE;
  logic [1:0]                M_AXI_ARBURST;
  logic                      M_AXI_ARVALID;
  logic                      M_AXI_ARREADY;
  logic [ID_WIDTH-1:0]       M_AXI_RID;
  logic [DATA_WIDTH-1:0]     M_AXI_RDATA;
  logic [1:0]                M_AXI_RRESP;
  logic                      M_AXI_RLAST;
  logic                      M_AXI_RVALID;
  logic                      M_AXI_RREADY;

  // Bridge view: Wishbone slave, AXI4 master.
  modport master (
    input  WB_CYC, WB_STB, WB_WE, WB_ADDR, WB_WDATA, WB_SEL,
    output WB_RDATA, WB_ACK, WB_ERR,
    output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  // Environment view: Wishbone initiator, AXI4 slave.
  modport slave (
    output WB_CYC, WB_STB, WB_WE, WB_ADDR, WB_WDATA, WB_SEL,
    input  WB_RDATA, WB_ACK, WB_ERR,
    input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    input  M_AXI_RREADY
  );

endinterface

// File: rtl/wishbone_to_axi4_master.sv
// Wishbone classic slave to single-beat AXI4 master bridge, one transaction outstanding.
module wishbone_to_axi4_master
  import wb_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  wishbone_to_axi4_master_if.master bus
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("DATA_WIDTH must be 32 or 64");
  end

  bridge_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] sel_q, sel_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  err_q, err_d;
  logic                  abort_q, abort_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      err_q     <= err_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    err_d     = err_q;
    abort_d   = abort_q;

    // The AXI side always runs to completion; a dropped cycle only suppresses the WB reply.
    if (state_q != StIdle && !bus.WB_CYC) abort_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        if (bus.WB_CYC && bus.WB_STB) begin
          addr_d  = bus.WB_ADDR;
          wdata_d = bus.WB_WDATA;
          sel_d   = bus.WB_SEL;
          err_d   = 1'b0;
          if (bus.WB_WE) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWrReq;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StRdReq;
          end
        end
      end
      StWrReq: begin
        // A cleared valid flag doubles as the "channel done" marker.
        if (awvalid_q && bus.M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && bus.M_AXI_WREADY) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = StWrResp;
      end
      StWrResp: begin
        if (bus.M_AXI_BVALID) begin
          err_d   = bus.M_AXI_BRESP[1];
          state_d = StDone;
        end
      end
      StRdReq: begin
        if (bus.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = StRdResp;
        end
      end
      StRdResp: begin
        if (bus.M_AXI_RVALID) begin
          rdata_d = bus.M_AXI_RDATA;
          err_d   = bus.M_AXI_RRESP[1];
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.WB_RDATA = rdata_q;
  assign bus.WB_ACK   = (state_q == StDone) && !err_q && !abort_q;
  assign bus.WB_ERR   = (state_q == StDone) && err_q && !abort_q;

  assign bus.M_AXI_AWID    = ID_WIDTH'(AXI_ID);
  assign bus.M_AXI_AWADDR  = addr_q;
  assign bus.M_AXI_AWLEN   = 8'd0;
  assign bus.M_AXI_AWSIZE  = axi_size(STRB_WIDTH);
  assign bus.M_AXI_AWBURST = AXI_BURST_INCR;
  assign bus.M_AXI_AWVALID = awvalid_q;
  assign bus.M_AXI_WDATA   = wdata_q;
  assign bus.M_AXI_WSTRB   = sel_q;
  assign bus.M_AXI_WLAST   = 1'b1;
  assign bus.M_AXI_WVALID  = wvalid_q;
  assign bus.M_AXI_BREADY  = (state_q == StWrResp);

  assign bus.M_AXI_ARID    = ID_WIDTH'(AXI_ID);
  assign bus.M_AXI_ARADDR  = addr_q;
  assign bus.M_AXI_ARLEN   = 8'd0;
  assign bus.M_AXI_ARSIZE  = axi_size(STRB_WIDTH);
  assign bus.M_AXI_ARBURST = AXI_BURST_INCR;
  assign bus.M_AXI_ARVALID = arvalid_q;
  assign bus.M_AXI_RREADY  = (state_q == StRdResp);

  logic unused_inputs;
  assign unused_inputs = ^{bus.M_AXI_BID, bus.M_AXI_RID, bus.M_AXI_RLAST,
                           bus.M_AXI_BRESP[0], bus.M_AXI_RRESP[0]};

endmodule

// File: tb/tb_wishbone_to_axi4_master.sv
// Self-checking bench: directed scenarios plus randomized transactions against a latency/response model.
module tb_wishbone_to_axi4_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned ID = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wishbone_to_axi4_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  wishbone_to_axi4_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ID_WIDTH  (IW),
    .AXI_ID    (ID)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.WB_CYC = 0; bus.WB_STB = 0; bus.WB_WE = 0;
    bus.WB_ADDR = '0; bus.WB_WDATA = '0; bus.WB_SEL = '0;
    bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_ARREADY = 0;
    bus.M_AXI_BID = '0; bus.M_AXI_BRESP = '0; bus.M_AXI_BVALID = 0;
    bus.M_AXI_RID = '0; bus.M_AXI_RDATA = '0; bus.M_AXI_RRESP = '0;
    bus.M_AXI_RLAST = 0; bus.M_AXI_RVALID = 0;
  endtask

  // Plays one Wishbone transaction and an AXI slave with the given ready/response delays.
  // Cycle 0 is the request cycle; fin_cyc is the first cycle showing ACK or ERR.
  task automatic run_xfer(
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  sel,
    input  int          aw_dly,
    input  int          w_dly,
    input  int          ar_dly,
    input  int          resp_dly,
    input  int          abort_c,
    input  logic [1:0]  resp,
    input  logic [31:0] rdata,
    output int          ack_n,
    output int          err_n,
    output int          fin_cyc,
    output int          hs_aw_c,
    output int          hs_w_c,
    output int          resp_n,
    output int          viol,
    output logic [31:0] rd_seen,
    output bit          timeout
  );
    int c, aw_cnt, w_cnt, ar_cnt, rsp_cnt, hs_ar_c, resp_hs_c;
    bit aw_hs, w_hs, ar_hs, aw_prev, w_prev, ar_prev;
    c = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; rsp_cnt = 0;
    hs_ar_c = -1; resp_hs_c = -1; hs_aw_c = -1; hs_w_c = -1;
    aw_hs = 0; w_hs = 0; ar_hs = 0; aw_prev = 0; w_prev = 0; ar_prev = 0;
    ack_n = 0; err_n = 0; fin_cyc = -1; resp_n = 0; viol = 0; rd_seen = '0; timeout = 1;
    bus.WB_CYC = 1; bus.WB_STB = 1; bus.WB_WE = we;
    bus.WB_ADDR = addr; bus.WB_WDATA = wdata; bus.WB_SEL = sel;
    while (c < 200) begin
      step();
      c++;
      if (bus.WB_ACK) ack_n++;
      if (bus.WB_ERR) err_n++;
      if ((bus.WB_ACK || bus.WB_ERR) && fin_cyc < 0) begin
        fin_cyc = c;
        rd_seen = bus.WB_RDATA;
      end
      if (bus.WB_ACK || bus.WB_ERR || c == abort_c) begin
        bus.WB_CYC = 0;
        bus.WB_STB = 0;
      end
      if (resp_hs_c >= 0 && c >= resp_hs_c + 3) begin
        timeout = 0;
        break;
      end
      // Protocol observations
      if (bus.M_AXI_BREADY && bus.M_AXI_RREADY) viol++;
      if (bus.M_AXI_BREADY && !we) viol++;
      if (bus.M_AXI_RREADY && we) viol++;
      if (aw_prev && !bus.M_AXI_AWVALID) viol++;
      if (w_prev && !bus.M_AXI_WVALID) viol++;
      if (ar_prev && !bus.M_AXI_ARVALID) viol++;
      if (bus.M_AXI_AWVALID && (aw_hs || !we || bus.M_AXI_AWADDR !== addr ||
          bus.M_AXI_AWLEN !== 8'd0 || bus.M_AXI_AWSIZE !== 3'd2 ||
          bus.M_AXI_AWBURST !== 2'b01 || bus.M_AXI_AWID !== 4'(ID))) viol++;
      if (bus.M_AXI_WVALID && (w_hs || !we || bus.M_AXI_WDATA !== wdata ||
          bus.M_AXI_WSTRB !== sel || bus.M_AXI_WLAST !== 1'b1)) viol++;
      if (bus.M_AXI_ARVALID && (ar_hs || we || bus.M_AXI_ARADDR !== addr ||
          bus.M_AXI_ARLEN !== 8'd0 || bus.M_AXI_ARSIZE !== 3'd2 ||
          bus.M_AXI_ARBURST !== 2'b01 || bus.M_AXI_ARID !== 4'(ID))) viol++;
      // Slave responder: handshakes complete at the coming edge.
      bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && (aw_cnt >= aw_dly);
      if (bus.M_AXI_AWVALID) aw_cnt++;
      aw_prev = bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY;
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin aw_hs = 1; hs_aw_c = c; end
      bus.M_AXI_WREADY = bus.M_AXI_WVALID && (w_cnt >= w_dly);
      if (bus.M_AXI_WVALID) w_cnt++;
      w_prev = bus.M_AXI_WVALID && !bus.M_AXI_WREADY;
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin w_hs = 1; hs_w_c = c; end
      bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && (ar_cnt >= ar_dly);
      if (bus.M_AXI_ARVALID) ar_cnt++;
      ar_prev = bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY;
      if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin ar_hs = 1; hs_ar_c = c; end
      bus.M_AXI_BVALID = 0;
      bus.M_AXI_RVALID = 0;
      if (resp_hs_c < 0 && we && aw_hs && w_hs && hs_aw_c < c && hs_w_c < c) begin
        bus.M_AXI_BVALID = (rsp_cnt >= resp_dly);
        bus.M_AXI_BRESP = resp;
        bus.M_AXI_BID = 4'(ID);
        rsp_cnt++;
        if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin resp_n++; resp_hs_c = c; end
      end
      if (resp_hs_c < 0 && !we && ar_hs && hs_ar_c < c) begin
        bus.M_AXI_RVALID = (rsp_cnt >= resp_dly);
        bus.M_AXI_RDATA = rdata;
        bus.M_AXI_RRESP = resp;
        bus.M_AXI_RID = 4'(ID);
        bus.M_AXI_RLAST = 1;
        rsp_cnt++;
        if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) begin resp_n++; resp_hs_c = c; end
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    step();
    step();
    checks++;
    if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID, bus.M_AXI_BREADY,
         bus.M_AXI_RREADY} !== 5'b0) begin
      failures++;
      $display("FAIL reset_handshakes got=%b expected=00000", {bus.M_AXI_AWVALID,
               bus.M_AXI_WVALID, bus.M_AXI_ARVALID, bus.M_AXI_BREADY, bus.M_AXI_RREADY});
    end
    checks++;
    if ({bus.WB_ACK, bus.WB_ERR} !== 2'b00) begin
      failures++;
      $display("FAIL reset_wb_resp got=%b expected=00", {bus.WB_ACK, bus.WB_ERR});
    end
    checks++;
    if ({bus.WB_RDATA, bus.M_AXI_AWADDR, bus.M_AXI_WDATA, bus.M_AXI_WSTRB} !== '0) begin
      failures++;
      $display("FAIL reset_data rdata=%h addr=%h wdata=%h strb=%h expected all 0",
               bus.WB_RDATA, bus.M_AXI_AWADDR, bus.M_AXI_WDATA, bus.M_AXI_WSTRB);
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_write_basic();
    int ack_n, err_n, fin, haw, hw, rn, viol;
    logic [31:0] rd;
    bit to;
    run_xfer(1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, -1, 2'b00, 32'h0,
             ack_n, err_n, fin, haw, hw, rn, viol, rd, to);
    checks++;
    if (to || ack_n !== 1 || err_n !== 0) begin
      failures++;
      $display("FAIL wr_basic_resp timeout=%0d ack=%0d err=%0d expected 0/1/0", to, ack_n, err_n);
    end
    checks++;
    if (fin !== 3) begin
      failures++;
      $display("FAIL wr_basic_latency cycle=%0d expected=3", fin);
    end
    checks++;
    if (viol !== 0 || rn !== 1) begin
      failures++;
      $display("FAIL wr_basic_protocol violations=%0d b=%0d expected 0/1", viol, rn);
    end
  endtask

  task automatic test_write_split();
    int ack_n, err_n, fin, haw, hw, rn, viol;
    logic [31:0] rd;
    bit to;
    run_xfer(1, 32'h0000_3008, 32'hCAFE_F00D, 4'h6, 4, 1, 0, 0, -1, 2'b01, 32'h0,
             ack_n, err_n, fin, haw, hw, rn, viol, rd, to);
    checks++;
    if (hw !== 2 || haw !== 5) begin
      failures++;
      $display("FAIL wr_split_order w_hs=%0d aw_hs=%0d expected 2/5", hw, haw);
    end
    checks++;
    if (to || ack_n !== 1 || err_n !== 0 || rn !== 1) begin
      failures++;
      $display("FAIL wr_split_resp to=%0d ack=%0d err=%0d b=%0d expected 0/1/0/1",
               to, ack_n, err_n, rn);
    end
    checks++;
    if (viol !== 0 || fin !== 7) begin
      failures++;
      $display("FAIL wr_split_protocol violations=%0d cycle=%0d expected 0/7", viol, fin);
    end
  endtask

  task automatic test_read_delay();
    int ack_n, err_n, fin, haw, hw, rn, viol;
    logic [31:0] rd;
    bit to;
    run_xfer(0, 32'h2004, 32'h0, 4'hF, 0, 0, 0, 5, -1, 2'b00, 32'h12345678,
             ack_n, err_n, fin, haw, hw, rn, viol, rd, to);
    checks++;
    if (rd !== 32'h12345678) begin
      failures++;
      $display("FAIL rd_delay_data got=%h expected=12345678", rd);
    end
    checks++;
    if (to || ack_n !== 1 || err_n !== 0 || fin !== 8) begin
      failures++;
      $display("FAIL rd_delay_ack to=%0d ack=%0d err=%0d cycle=%0d expected 0/1/0/8",
               to, ack_n, err_n, fin);
    end
    checks++;
    if (viol !== 0 || rn !== 1) begin
      failures++;
      $display("FAIL rd_delay_protocol violations=%0d r=%0d expected 0/1", viol, rn);
    end
  endtask

  task automatic test_read_decerr();
    int ack_n, err_n, fin, haw, hw, rn, viol;
    logic [31:0] rd;
    bit to;
    run_xfer(0, 32'h4000, 32'h0, 4'hF, 0, 0, 1, 0, -1, 2'b11, 32'h5555AAAA,
             ack_n, err_n, fin, haw, hw, rn, viol, rd, to);
    checks++;
    if (to || err_n !== 1 || ack_n !== 0) begin
      failures++;
      $display("FAIL rd_decerr to=%0d err=%0d ack=%0d expected 0/1/0", to, err_n, ack_n);
    end
    checks++;
    if (fin !== 4 || viol !== 0) begin
      failures++;
      $display("FAIL rd_decerr_timing cycle=%0d violations=%0d expected 4/0", fin, viol);
    end
  endtask

  task automatic test_abort();
    int ack_n, err_n, fin, haw, hw, rn, viol;
    logic [31:0] rd;
    bit to;
    run_xfer(0, 32'h5000, 32'h0, 4'hF, 0, 0, 3, 1, 1, 2'b00, 32'h0BAD0BAD,
             ack_n, err_n, fin, haw, hw, rn, viol, rd, to);
    checks++;
    if (to || ack_n !== 0 || err_n !== 0) begin
      failures++;
      $display("FAIL abort_silent to=%0d ack=%0d err=%0d expected 0/0/0", to, ack_n, err_n);
    end
    checks++;
    if (rn !== 1 || viol !== 0) begin
      failures++;
      $display("FAIL abort_axi_complete r=%0d violations=%0d expected 1/0", rn, viol);
    end
    run_xfer(0, 32'h5004, 32'h0, 4'hF, 0, 0, 0, 0, -1, 2'b00, 32'h600DF00D,
             ack_n, err_n, fin, haw, hw, rn, viol, rd, to);
    checks++;
    if (to || ack_n !== 1 || rd !== 32'h600DF00D || fin !== 3) begin
      failures++;
      $display("FAIL abort_next_read ack=%0d data=%h cycle=%0d expected 1/600df00d/3",
               ack_n, rd, fin);
    end
  endtask

  task automatic test_reset_mid();
    int ack_n, err_n, fin, haw, hw, rn, viol;
    logic [31:0] rd;
    bit to;
    int seen;
    bus.WB_CYC = 1; bus.WB_STB = 1; bus.WB_WE = 1;
    bus.WB_ADDR = 32'h7000; bus.WB_WDATA = 32'h11112222; bus.WB_SEL = 4'h3;
    bus.M_AXI_AWREADY = 1; bus.M_AXI_WREADY = 1;
    step();
    step();
    checks++;
    if (bus.M_AXI_BREADY !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_bready got=%b expected=1", bus.M_AXI_BREADY);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID, bus.M_AXI_BREADY,
         bus.M_AXI_RREADY, bus.WB_ACK, bus.WB_ERR} !== 7'b0 || bus.M_AXI_AWADDR !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs ctl=%b addr=%h expected all 0", {bus.M_AXI_AWVALID,
               bus.M_AXI_WVALID, bus.M_AXI_ARVALID, bus.M_AXI_BREADY, bus.M_AXI_RREADY,
               bus.WB_ACK, bus.WB_ERR}, bus.M_AXI_AWADDR);
    end
    clear_inputs();
    step();
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.WB_ACK || bus.WB_ERR || bus.M_AXI_BREADY || bus.M_AXI_AWVALID) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL rst_mid_idle activity_cycles=%0d expected=0", seen);
    end
    run_xfer(1, 32'h7004, 32'h33334444, 4'hC, 0, 0, 0, 0, -1, 2'b00, 32'h0,
             ack_n, err_n, fin, haw, hw, rn, viol, rd, to);
    checks++;
    if (to || ack_n !== 1 || fin !== 3 || viol !== 0) begin
      failures++;
      $display("FAIL rst_mid_recover ack=%0d cycle=%0d violations=%0d expected 1/3/0",
               ack_n, fin, viol);
    end
  endtask

  task automatic test_random();
    int ack_n, err_n, fin, haw, hw, rn, viol;
    logic [31:0] rd;
    bit to;
    for (int t = 0; t < 24; t++) begin
      logic        we;
      logic [31:0] addr, wdata, rdata;
      logic [3:0]  sel;
      logic [1:0]  resp;
      int aw_d, w_d, ar_d, r_d, ab, exp_fin, exp_ack, exp_err;
      we    = 1'($urandom_range(0, 1));
      addr  = $urandom & 32'hFFFF_FFFC;
      wdata = $urandom;
      rdata = $urandom;
      sel   = 4'($urandom_range(1, 15));
      resp  = 2'($urandom_range(0, 3));
      aw_d  = $urandom_range(0, 3);
      w_d   = $urandom_range(0, 3);
      ar_d  = $urandom_range(0, 3);
      r_d   = $urandom_range(0, 3);
      ab    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : -1;
      // Reference: request -> address/data phase -> response phase -> one DONE cycle.
      exp_fin = we ? 3 + ((aw_d > w_d) ? aw_d : w_d) + r_d : 3 + ar_d + r_d;
      exp_ack = (ab < 0 && !resp[1]) ? 1 : 0;
      exp_err = (ab < 0 && resp[1]) ? 1 : 0;
      run_xfer(we, addr, wdata, sel, aw_d, w_d, ar_d, r_d, ab, resp, rdata,
               ack_n, err_n, fin, haw, hw, rn, viol, rd, to);
      checks++;
      if (to || ack_n !== exp_ack || err_n !== exp_err || rn !== 1) begin
        failures++;
        $display("FAIL rand_resp t=%0d we=%0d resp=%0d abort=%0d ack=%0d err=%0d axi=%0d to=%0d exp_ack=%0d exp_err=%0d",
                 t, we, resp, ab, ack_n, err_n, rn, to, exp_ack, exp_err);
      end
      checks++;
      if (viol !== 0) begin
        failures++;
        $display("FAIL rand_protocol t=%0d violations=%0d expected=0", t, viol);
      end
      if (ab < 0) begin
        checks++;
        if (fin !== exp_fin) begin
          failures++;
          $display("FAIL rand_latency t=%0d cycle=%0d expected=%0d", t, fin, exp_fin);
        end
      end
      if (exp_ack == 1 && !we) begin
        checks++;
        if (rd !== rdata) begin
          failures++;
          $display("FAIL rand_rdata t=%0d got=%h expected=%h", t, rd, rdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_split();
    test_read_delay();
    test_read_decerr();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
